// File: rtl/buff_drain.sv
// Drains an upstream circular buffer into a valid/ready stream via a 2-entry skid stage,
// keeping a mirror of the buffer occupancy and a sticky overflow flag.
module buff_drain #(
  parameter int NUMELEM = 4,
  parameter int BITDATA = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  output logic                       o_can_push,
  output logic                       o_pop,
  input  logic [BITDATA-1:0]         i_po_dout,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [BITDATA-1:0]         o_m_data,
  output logic [$clog2(NUMELEM):0]   o_occ,
  output logic                       o_ovf
);

  localparam int OCCW = $clog2(NUMELEM) + 1;
  localparam logic [OCCW-1:0] OCC_FULL = OCCW'(NUMELEM);

  // state    | meaning
  // ST_EMPTY | skid stage holds no word
  // ST_ONE   | slot0 holds the head word
  // ST_TWO   | slot0 head, slot1 next; no pop allowed
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  logic [OCCW-1:0]    r_occ;
  logic               r_ovf;
  logic [BITDATA-1:0] r_slot0;
  logic [BITDATA-1:0] r_slot1;

  logic w_pop;
  logic w_take;
  logic w_full;

  assign w_full     = (r_occ == OCC_FULL);
  assign w_pop      = (r_occ != '0) && (r_state != ST_TWO);
  assign w_take     = o_m_valid && i_m_ready;

  assign o_pop      = w_pop;
  assign o_can_push = (r_occ < OCC_FULL);
  assign o_m_valid  = (r_state != ST_EMPTY);
  assign o_m_data   = r_slot0;
  assign o_occ      = r_occ;
  assign o_ovf      = r_ovf;

  // A push into a full buffer with no pop is dropped upstream: occ saturates, ovf sticks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else if (i_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else begin
      r_occ <= r_occ + OCCW'(i_push) - OCCW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            r_slot0 <= i_po_dout;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_pop && w_take) begin
            r_slot0 <= i_po_dout;
          end else if (w_pop) begin
            r_slot1 <= i_po_dout;
            r_state <= ST_TWO;
          end else if (w_take) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            r_slot0 <= r_slot1;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_buff_drain.sv
// Directed vector table plus randomized traffic against a queue model of the upstream buffer.
module tb_buff_drain;

  localparam int NUMELEM = 4;
  localparam int BITDATA = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               push;
  logic               can_push;
  logic               pop;
  logic [BITDATA-1:0] po_dout;
  logic               m_valid;
  logic               m_ready;
  logic [BITDATA-1:0] m_data;
  logic [2:0]         occ;
  logic               ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [BITDATA-1:0] up_q[$];
  logic [BITDATA-1:0] exp_q[$];
  logic [BITDATA-1:0] din;

  buff_drain #(.NUMELEM(NUMELEM), .BITDATA(BITDATA)) dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .o_can_push(can_push), .o_pop(pop),
    .i_po_dout(po_dout), .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_occ(occ), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  // upstream circular buffer model; drops a push when full
  always @(posedge clk) begin
    if (rst) begin
      up_q.delete();
    end else begin
      if (pop && up_q.size() > 0) void'(up_q.pop_front());
      if (push && up_q.size() < NUMELEM) up_q.push_back(din);
    end
    po_dout <= (up_q.size() > 0) ? up_q[0] : '0;
  end

  typedef struct {
    bit rst; bit push; logic [3:0] din; bit rdy; bit chk;
    bit pop; bit vld; logic [3:0] dat; int occ; bit cp; bit ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, bit p, logic [3:0] d, bit rdy, bit c,
                             bit e_pop, bit e_vld, logic [3:0] e_dat, int e_occ, bit e_cp, bit e_ovf);
    vec_t x;
    x.rst = r; x.push = p; x.din = d; x.rdy = rdy; x.chk = c;
    x.pop = e_pop; x.vld = e_vld; x.dat = e_dat; x.occ = e_occ; x.cp = e_cp; x.ovf = e_ovf;
    return x;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; din = '0; m_ready = 1'b0; po_dout = '0;

    // single push of 0xA
    tbl.push_back(v(1,0,4'h0,1,0, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,1,4'hA,1,1, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 1,0,4'h0,1,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 0,1,4'hA,0,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 0,0,4'h0,0,1,0));
    // streaming 1..4 at full rate
    tbl.push_back(v(0,1,4'h1,1,1, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,1,4'h2,1,1, 1,0,4'h0,1,1,0));
    tbl.push_back(v(0,1,4'h3,1,1, 1,1,4'h1,1,1,0));
    tbl.push_back(v(0,1,4'h4,1,1, 1,1,4'h2,1,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 1,1,4'h3,1,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 0,1,4'h4,0,1,0));
    tbl.push_back(v(0,0,4'h0,1,1, 0,0,4'h0,0,1,0));
    // backpressure, fill, overflow, then drain
    tbl.push_back(v(0,1,4'h5,0,1, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,1,4'h6,0,1, 1,0,4'h0,1,1,0));
    tbl.push_back(v(0,1,4'h7,0,1, 1,1,4'h5,1,1,0));
    tbl.push_back(v(0,1,4'h8,0,1, 0,1,4'h5,1,1,0));
    tbl.push_back(v(0,0,4'h0,0,1, 0,1,4'h5,2,1,0));
    tbl.push_back(v(0,1,4'h9,0,1, 0,1,4'h5,2,1,0));
    tbl.push_back(v(0,1,4'hB,0,1, 0,1,4'h5,3,1,0));
    tbl.push_back(v(0,1,4'hC,0,1, 0,1,4'h5,4,0,0));
    tbl.push_back(v(0,0,4'h0,0,1, 0,1,4'h5,4,0,1));
    tbl.push_back(v(0,0,4'h0,1,1, 0,1,4'h5,4,0,1));
    tbl.push_back(v(0,0,4'h0,1,1, 1,1,4'h6,4,0,1));
    tbl.push_back(v(0,0,4'h0,1,1, 1,1,4'h7,3,1,1));
    tbl.push_back(v(0,0,4'h0,1,1, 1,1,4'h8,2,1,1));
    tbl.push_back(v(0,0,4'h0,1,1, 1,1,4'h9,1,1,1));
    tbl.push_back(v(0,0,4'h0,1,1, 0,1,4'hB,0,1,1));
    tbl.push_back(v(0,0,4'h0,1,1, 0,0,4'h0,0,1,1));
    // reset with two words in skid and occ=3
    tbl.push_back(v(1,0,4'h0,0,0, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,1,4'h1,0,1, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,1,4'h2,0,1, 1,0,4'h0,1,1,0));
    tbl.push_back(v(0,1,4'h3,0,1, 1,1,4'h1,1,1,0));
    tbl.push_back(v(0,1,4'h4,0,1, 0,1,4'h1,1,1,0));
    tbl.push_back(v(0,1,4'h5,0,1, 0,1,4'h1,2,1,0));
    tbl.push_back(v(0,0,4'h0,0,1, 0,1,4'h1,3,1,0));
    tbl.push_back(v(1,0,4'h0,0,0, 0,0,4'h0,0,1,0));
    tbl.push_back(v(0,0,4'h0,0,1, 0,0,4'h0,0,1,0));

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; push = tbl[i].push; din = tbl[i].din; m_ready = tbl[i].rdy;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d pop", i), int'(pop), int'(tbl[i].pop));
        chk($sformatf("v%0d m_valid", i), int'(m_valid), int'(tbl[i].vld));
        if (tbl[i].vld) chk($sformatf("v%0d m_data", i), int'(m_data), int'(tbl[i].dat));
        chk($sformatf("v%0d occ", i), int'(occ), tbl[i].occ);
        chk($sformatf("v%0d can_push", i), int'(can_push), int'(tbl[i].cp));
        chk($sformatf("v%0d ovf", i), int'(ovf), int'(tbl[i].ovf));
      end
    end

    // random traffic obeying can_push, random consumer ready
    @(posedge clk); #1;
    rst = 1'b1; push = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      push = can_push && ($urandom_range(0, 3) != 0);
      din = 4'($urandom_range(0, 15));
      m_ready = ($urandom_range(0, 2) != 0);
      if (push) exp_q.push_back(din);
      @(negedge clk);
      chk("rand pop_when_empty", int'(pop && occ == 0), 0);
      chk("rand occ_model", int'(occ), up_q.size());
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("rand extra_word", 1, 0);
        else chk("rand m_data", int'(m_data), int'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
    end
    push = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid) begin
        if (exp_q.size() == 0) chk("drain extra_word", 1, 0);
        else chk("drain m_data", int'(m_data), int'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_valid && occ == 0) break;
    end
    chk("drain words_left", exp_q.size(), 0);
    chk("drain occ", int'(occ), 0);
    chk("final ovf", int'(ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buff_drain.md
BUFF_DRAIN -- requirements
Module: buff_drain

Interface
- REQ-001 Parameter NUMELEM, default 4: capacity of the upstream circular buffer being drained (entries).
- REQ-002 Parameter BITDATA, default 4: data width of buffer entries and output stream.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-005 push  input  1  copy of the push strobe applied to the upstream buffer this cycle.
- REQ-006 can_push  output  1  high when the upstream buffer may accept a push this cycle.
- REQ-007 pop  output  1  pop strobe driven to the upstream buffer (combinational).
- REQ-008 po_dout  input  BITDATA  head data of the upstream buffer, valid in any cycle where occ>0.
- REQ-009 m_valid  output  1  output stream valid.
- REQ-010 m_ready  input  1  output stream ready from the consumer.
- REQ-011 m_data  output  BITDATA  output stream data.
- REQ-012 occ  output  $clog2(NUMELEM)+1  mirrored upstream buffer occupancy.
- REQ-013 ovf  output  1  sticky error: push seen while mirrored buffer was full.

Function
- REQ-014 occ SHALL update each cycle as occ + push - pop; width $clog2(NUMELEM)+1, no wrap in legal operation.
- REQ-015 can_push SHALL equal (occ < NUMELEM), registered-state-derived, independent of pop in the same cycle.
- REQ-016 pop SHALL equal (occ != 0) && (sk_cnt < 2); pop SHALL never assert when occ==0.
- REQ-017 Output stage SHALL be a 2-entry skid buffer with states EMPTY (sk_cnt=0), ONE (1), TWO (2); slot0 is the head.
- REQ-018 take = m_valid && m_ready; on pop, po_dout SHALL be written to slot0 if the stage is EMPTY or (ONE with take), else to slot1.
- REQ-019 On take in TWO, slot1 SHALL move to slot0; sk_cnt SHALL update as sk_cnt + pop - take.
- REQ-020 Transitions: EMPTY->ONE on pop; ONE->TWO on pop&!take; ONE->EMPTY on take&!pop; TWO->ONE on take (pop is 0 in TWO); otherwise hold.
- REQ-021 m_valid SHALL equal (sk_cnt != 0); m_data SHALL equal slot0; m_data SHALL be stable while m_valid && !m_ready.
- REQ-022 Latency: a push in cycle t (buffer empty, stage EMPTY) SHALL give pop in t+1 and m_valid with that data in t+2.
- REQ-023 Throughput: with m_ready held high and push every cycle, one word SHALL leave per cycle in steady state (sk_cnt stays ONE).
- REQ-024 Simultaneous push and pop SHALL leave occ unchanged.
- REQ-025 Backpressure: with m_ready low, at most 2 words SHALL be popped; further words SHALL remain in the upstream buffer.
- REQ-026 Data order at m_data SHALL equal push order, with no loss or duplication.
- REQ-027 ovf SHALL set on the edge after any cycle with push && occ==NUMELEM && !pop, and SHALL hold until reset; occ SHALL saturate at NUMELEM in that case.

Reset
- REQ-028 While rst is high at a clock edge: occ=0, sk_cnt=0 (EMPTY), ovf=0; after that edge m_valid=0, pop=0, can_push=1.
- REQ-029 Reset mid-operation SHALL discard skid contents and the occupancy mirror; the upstream buffer SHALL be reset in the same cycle by the integrator.
- REQ-030 Slot data registers need no reset; m_data is don't-care while m_valid=0.

Verification
- REQ-031 Reset then single push of 0xA, m_ready=1 -> pop in t+1, m_valid=1 and m_data=0xA in t+2, m_valid=0 in t+3.
- REQ-032 Push 0x1,0x2,0x3,0x4 on consecutive cycles, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles, occ peaks at 1.
- REQ-033 m_ready=0, push 4 words -> exactly 2 pops, sk_cnt=2, occ=2, can_push=1; raise m_ready -> remaining words drain in order.
- REQ-034 m_ready=0, fill to occ=4 with sk_cnt=2 -> can_push=0; extra push -> ovf=1 next cycle and stays 1.
- REQ-035 Random push (obeying can_push) and random m_ready against a buffer model -> output sequence matches push sequence; pop never asserts when occ=0.
- REQ-036 rst asserted with sk_cnt=2, occ=3 -> next cycle m_valid=0, occ=0, ovf=0, can_push=1.
